// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES state type, FSM states and InvShiftRows wiring helper
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    // FIPS byte i sits in element 15-i, so byte 0 is the most significant byte
    typedef logic [AES_BLOCK_BYTES-1:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_t;

    // out[r][c] = in[r][(c-r) mod 4], byte index 4c+r
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[AES_BLOCK_BYTES-1-(4*c+r)] = s[AES_BLOCK_BYTES-1-(4*((c-r+4)%4)+r)];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational AES inverse S-box, one byte in, one byte out
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
            8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
            8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
            8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
            8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
            8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
            8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
            8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
            8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
            8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
            8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
            8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
            8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
            8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
            8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
            8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
            8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
            8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
            8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
            8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
            8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
            8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
            8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
            8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
            8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
            8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
            8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
            8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
            8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
            8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
            8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
            8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_inv_subbytes.sv
// rtl/aes_inv_subbytes.sv - lane-serial AES InvSubBytes block; AES_INV_SUBBYTES_INV_SHIFTROWS_EN adds InvShiftRows at capture
module aes_inv_subbytes
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int STEPS = AES_BLOCK_BYTES / SBOX_LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_subbytes: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    aes_fsm_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    aes_state_t st_q, st_d;
    aes_state_t cap_data;

`ifdef AES_INV_SUBBYTES_INV_SHIFTROWS_EN
    assign cap_data = inv_shift_rows(in_data);
`else
    assign cap_data = in_data;
`endif

    logic [7:0] lane_in  [SBOX_LANES];
    logic [7:0] lane_out [SBOX_LANES];
    logic [3:0] lane_idx [SBOX_LANES];

    // lane j of step k works on FIPS byte k*L+j
    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        assign lane_idx[j] = 4'(int'(cnt_q) * SBOX_LANES + j);
        assign lane_in[j]  = st_q[4'(AES_BLOCK_BYTES-1) - lane_idx[j]];
        aes_inv_sbox u_sbox (
            .a (lane_in[j]),
            .y (lane_out[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_d    = cap_data;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    st_d[4'(AES_BLOCK_BYTES-1) - lane_idx[j]] = lane_out[j];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    // handshake outputs depend on registered state only
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// tb/tb_aes_inv_subbytes.sv - self-checking bench for aes_inv_subbytes at 1, 4 and 16 lanes
module tb_aes_inv_subbytes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] out_data1;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] out_data16;

    aes_inv_subbytes #(.SBOX_LANES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    aes_inv_subbytes #(.SBOX_LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
    );
    aes_inv_subbytes #(.SBOX_LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;
    vec_t vt [4];

    // GF(2^8) multiply with the AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // forward S-box from inverse + affine map, then inverted into a table
    task automatic build_tables();
        logic [7:0] b, s;
        for (int a = 0; a < 256; a++) begin
            b = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            inv_tab[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] din);
        logic [7:0] m [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = din[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
`ifdef AES_INV_SUBBYTES_INV_SHIFTROWS_EN
                o[127-8*(4*c+r) -: 8] = inv_tab[m[r][(c + 4 - r) % 4]];
`else
                o[127-8*(4*c+r) -: 8] = inv_tab[m[r][c]];
`endif
            end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input string name, input logic [127:0] d, input int hold,
                              output logic [127:0] res);
        int t = 0;
        int lat = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd4);
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, "_hold_data"}, out_data, res);
            chk({name, "_hold_inready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle_after"}, 128'({in_ready, out_valid, busy}), 128'b100);
    endtask

    initial begin
        logic [127:0] res, da, db;
        int lat, l1, l4, l16;
        build_tables();
        vt[0] = '{128'h63636363636363636363636363636363, 128'h0};
`ifdef AES_INV_SUBBYTES_INV_SHIFTROWS_EN
        vt[1] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000d0a0704010e0b0805020f0c090603};
`else
        vt[1] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
`endif
        vt[2] = '{128'h0, {16{8'h52}}};
        vt[3] = '{{16{8'h16}}, {16{8'hff}}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_flags", 128'({in_ready, out_valid, busy}), 128'b100);
        chk("reset_data", out_data, 128'h0);

        for (int i = 0; i < 4; i++) begin
            send_block($sformatf("vec%0d", i), vt[i].din, i, res);
            chk($sformatf("vec%0d_data", i), res, vt[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            da = {$urandom, $urandom, $urandom, $urandom};
            send_block("rand", da, $urandom_range(0, 3), res);
            chk("rand_data", res, model(da));
        end

        da = {$urandom, $urandom, $urandom, $urandom};
        send_block("bp10", da, 10, res);
        chk("bp10_data", res, model(da));

        // lane-count latencies from one shared accept edge
        rst = 1'b1; step(); rst = 1'b0;
        in_data = vt[1].din; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        l1 = 0; l4 = 0; l16 = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (out_valid1 && l1 == 0) l1 = n;
            if (out_valid && l4 == 0) l4 = n;
            if (out_valid16 && l16 == 0) l16 = n;
        end
        chk("lat_l1", 128'(l1), 128'd16);
        chk("lat_l4", 128'(l4), 128'd4);
        chk("lat_l16", 128'(l16), 128'd1);
        chk("data_l1", out_data1, vt[1].exp);
        chk("data_l4", out_data, vt[1].exp);
        chk("data_l16", out_data16, vt[1].exp);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // reset at BUSY cycle 2
        da = {$urandom, $urandom, $urandom, $urandom};
        in_data = da; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("midrst_busy_before", 128'(busy), 128'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_flags", 128'({in_ready, out_valid, busy}), 128'b100);
        chk("midrst_data", out_data, 128'h0);
        send_block("postrst", vt[1].din, 0, res);
        chk("postrst_data", res, vt[1].exp);

        // in_valid held with a new value while busy
        da = {$urandom, $urandom, $urandom, $urandom};
        db = {$urandom, $urandom, $urandom, $urandom};
        in_data = da; in_valid = 1'b1;
        step();
        in_data = db;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("hold_iv_latency", 128'(lat), 128'd4);
        chk("hold_iv_first", out_data, model(da));
        chk("hold_iv_inready", 128'(in_ready), 128'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("hold_iv_idle", 128'({in_ready, busy}), 128'b10);
        step();
        in_valid = 1'b0;
        chk("hold_iv_second_accept", 128'(busy), 128'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("hold_iv_second", out_data, model(db));
        out_ready = 1'b1; step(); out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_subbytes.md
AES_INV_SUBBYTES -- requirements
Module: aes_inv_subbytes

Interface
REQ-001 SHALL have parameter SBOX_LANES, default 4: inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, 128 bits: ciphertext-side state; byte i = bits [127-8i -: 8], FIPS-197 order.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 128 bits: InvSubBytes result, same byte order as in_data.
REQ-010 SHALL have port busy, output, 1 bit: high in BUSY and DONE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 In IDLE: in_ready=1, out_valid=0; in_valid=1 captures in_data into the state register, clears the lane counter and enters BUSY.
REQ-013 In BUSY: each cycle SHALL replace bytes [k*L .. k*L+L-1] (L=SBOX_LANES, k=counter) with InvSbox(byte) and increment k; at k=16/L-1 the FSM enters DONE.
REQ-014 Latency from the accept edge to out_valid=1 SHALL be exactly 16/SBOX_LANES cycles (4 at the default).
REQ-015 In DONE: out_valid=1 and out_data=state register; out_ready=1 returns the FSM to IDLE on that edge.
REQ-016 out_data SHALL hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
REQ-017 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored without corrupting the block in flight.
REQ-018 The minimum back-to-back issue interval SHALL be 16/L+2 cycles: accept, L-dependent processing, DONE, IDLE.
REQ-019 The InvSbox SHALL be the exact inverse of the FIPS-197 S-box for all 256 inputs, e.g. 0x63->0x00, 0x7c->0x01, 0x00->0x52, 0x16->0xff.
REQ-020 The design SHALL contain no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-021 With rst=1 at a clock edge: FSM=IDLE, counter=0, state register=0, out_valid=0, busy=0, in_ready=1 after the edge.
REQ-022 Reset asserted in BUSY or DONE SHALL abandon the block; out_data SHALL read 0 afterwards.
REQ-023 Reset SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-024 Macro AES_INV_SUBBYTES_INV_SHIFTROWS_EN defined: in_data SHALL pass through InvShiftRows before capture, out[r][c]=in[r][(c-r) mod 4], byte index 4c+r. The operation SHALL be pure wiring and add no latency.
REQ-025 Macro AES_INV_SUBBYTES_INV_SHIFTROWS_EN undefined: in_data SHALL be captured unchanged; the output is InvSubBytes only.

Structure
REQ-026 A shared package aes_pkg SHALL hold the FSM state enumeration, the 128-bit state type and the constant AES_BLOCK_BYTES=16.
REQ-027 The lookup SHALL be one sub-module, aes_inv_sbox (8-bit in, 8-bit out, combinational case table), instantiated SBOX_LANES times.

Verification
REQ-028 The bench SHALL cover: in_data=0x63636363636363636363636363636363, SBOX_LANES=4 -> out_valid exactly 4 cycles after accept, out_data=0x0.
REQ-029 The bench SHALL cover: in_data=0x637c777bf26b6fc53001672bfed7ab76, macro undefined, SBOX_LANES in {1, 16} -> out_data=0x000102030405060708090a0b0c0d0e0f, latency 16 cycles and 1 cycle respectively.
REQ-030 The bench SHALL cover: same input, macro defined -> out_data=0x000d0a0704010e0b0805020f0c090603.
REQ-031 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE, then 1 -> out_data stable throughout, in_ready=0 throughout, IDLE one cycle after the handshake.
REQ-032 The bench SHALL cover: rst pulsed 1 cycle at BUSY cycle 2 -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0; a new block then completes correctly.
REQ-033 The bench SHALL cover: in_valid held 1 with a new value while BUSY -> the first result is unchanged and the second block is accepted only in the next IDLE.
